// File: rtl/tetris_input_pkg.sv
// Shared timing constants and repeat-FSM encoding for the push-button input path.
// Real-time defaults assume a 50 MHz clock; the SIM_* values shrink them for simulation.
package tetris_input_pkg;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
    localparam int unsigned DEF_DAS_CYCLES      = 8_500_000;   // 170 ms
    localparam int unsigned DEF_ARR_CYCLES      = 2_500_000;   // 50 ms

    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_DAS_CYCLES      = 10;
    localparam int unsigned SIM_ARR_CYCLES      = 3;

    localparam int unsigned NUM_BTN   = 3;
    localparam int unsigned NUM_RPT   = 2;
    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_ROT   = 2;

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_DAS  = 2'd1,
        RPT_ARR  = 2'd2
    } rpt_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button path: synchronizer for an asynchronous active-low key, a debouncer that
// accepts a level only after it has been stable long enough, and a press-edge detector.
module debounce_channel
    import tetris_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic srst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_evt_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_pressed;
    logic                   level_q;
    logic                   level_d;
    logic                   level_prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    // Raw key is active-low, so the chain idles at all-ones ("released").
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_i};
        end
    end

    assign synced_pressed = ~sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (synced_pressed != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o     = level_q;
    assign press_evt_o = level_q & ~level_prev_q;

endmodule

// File: rtl/input_conditioner.sv
// Turns the left/right/rotate push-buttons into clean one-cycle move pulses for the
// game logic, with delayed auto-shift repeat on left/right and a left+right conflict mask.
module input_conditioner
    import tetris_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned DAS_CYCLES      = DEF_DAS_CYCLES,
    parameter int unsigned ARR_CYCLES      = DEF_ARR_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       key_rot_n,
    output logic       left_final,
    output logic       right_final,
    output logic       rot_final,
    output logic [2:0] btn_held
);

    localparam int unsigned TMR_W = $clog2(max_u(DAS_CYCLES, ARR_CYCLES) + 1);
    localparam logic [TMR_W-1:0] DAS_LOAD = TMR_W'(DAS_CYCLES);
    localparam logic [TMR_W-1:0] ARR_LOAD = TMR_W'(ARR_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [NUM_BTN-1:0] keys_n;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press_evt;
    logic [NUM_RPT-1:0] rpt_pulse;
    logic               both_held;
    logic               left_final_q;
    logic               right_final_q;
    logic               rot_final_q;

    assign keys_n = {key_rot_n, key_right_n, key_left_n};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            debounce_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .clk        (CLOCK_50),
                .srst       (reset),
                .key_n_i    (keys_n[gi]),
                .level_o    (level[gi]),
                .press_evt_o(press_evt[gi])
            );
        end

        for (gi = 0; gi < NUM_RPT; gi++) begin : g_rpt
            rpt_state_e       state_q;
            rpt_state_e       state_d;
            logic [TMR_W-1:0] timer_q;
            logic [TMR_W-1:0] timer_d;
            logic             pulse_d;

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    state_q <= RPT_IDLE;
                    timer_q <= '0;
                end else begin
                    state_q <= state_d;
                    timer_q <= timer_d;
                end
            end

            // A release seen in DAS/ARR suppresses any pulse due on the same cycle.
            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                pulse_d = 1'b0;
                case (state_q)
                    RPT_IDLE: begin
                        if (press_evt[gi]) begin
                            pulse_d = 1'b1;
                            timer_d = DAS_LOAD;
                            state_d = RPT_DAS;
                        end
                    end
                    RPT_DAS: begin
                        if (!level[gi]) begin
                            timer_d = '0;
                            state_d = RPT_IDLE;
                        end else if (timer_q == TMR_ONE) begin
                            pulse_d = 1'b1;
                            timer_d = ARR_LOAD;
                            state_d = RPT_ARR;
                        end else begin
                            timer_d = timer_q - 1'b1;
                        end
                    end
                    RPT_ARR: begin
                        if (!level[gi]) begin
                            timer_d = '0;
                            state_d = RPT_IDLE;
                        end else if (timer_q == TMR_ONE) begin
                            pulse_d = 1'b1;
                            timer_d = ARR_LOAD;
                        end else begin
                            timer_d = timer_q - 1'b1;
                        end
                    end
                    default: begin
                        timer_d = '0;
                        state_d = RPT_IDLE;
                    end
                endcase
            end

            assign rpt_pulse[gi] = pulse_d;
        end
    endgenerate

    // Both directions held: mute the move pulses but let the FSMs keep their cadence.
    assign both_held = level[BTN_LEFT] & level[BTN_RIGHT];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            left_final_q  <= 1'b0;
            right_final_q <= 1'b0;
            rot_final_q   <= 1'b0;
        end else begin
            left_final_q  <= rpt_pulse[BTN_LEFT] & ~both_held;
            right_final_q <= rpt_pulse[BTN_RIGHT] & ~both_held;
            rot_final_q   <= press_evt[BTN_ROT];
        end
    end

    assign left_final  = left_final_q;
    assign right_final = right_final_q;
    assign rot_final   = rot_final_q;
    assign btn_held    = level;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random key activity,
// compared every cycle against a history-based model of debounce and auto-repeat timing.
module tb_input_conditioner;
    import tetris_input_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = int'(SIM_DEBOUNCE_CYCLES);
    localparam int DAS  = int'(SIM_DAS_CYCLES);
    localparam int ARR  = int'(SIM_ARR_CYCLES);
    localparam int HMAX = 2048;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       key_left_n = 1'b1;
    logic       key_right_n = 1'b1;
    logic       key_rot_n = 1'b1;
    logic       left_final;
    logic       right_final;
    logic       rot_final;
    logic [2:0] btn_held;

    always #5 CLOCK_50 = ~CLOCK_50;

    input_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .DAS_CYCLES     (DAS),
        .ARR_CYCLES     (ARR)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_left_n (key_left_n),
        .key_right_n(key_right_n),
        .key_rot_n  (key_rot_n),
        .left_final (left_final),
        .right_final(right_final),
        .rot_final  (rot_final),
        .btn_held   (btn_held)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: k counts edges since reset was last sampled high.
    int       k = 0;
    bit       p_hist [3][HMAX];
    bit       d_hist [3][HMAX];
    int       last_flip [3];
    int       rise_edge [3];
    bit       exp_l, exp_r, exp_rot;
    bit [2:0] exp_held;

    function automatic bit synced_after(input int c, input int j);
        int idx = j - SYNC + 1;
        return (idx >= 1) ? p_hist[c][idx] : 1'b0;
    endfunction

    // Debounced level flips once DEB consecutive edges since the last flip saw a differing synced level.
    function automatic bit deb_flips(input int c);
        bit dp = d_hist[c][k-1];
        for (int j = k - DEB + 1; j <= k; j++) begin
            if (j <= last_flip[c]) return 1'b0;
            if (synced_after(c, j - 1) == dp) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Pulse at press+1, press+1+DAS, then every ARR, while the debounced level stays pressed.
    function automatic bit rpt_due(input int c);
        int t;
        if (!d_hist[c][k-1]) return 1'b0;
        t = k - (rise_edge[c] + 1);
        return (t == 0) || (t == DAS) || (t > DAS && ((t - DAS) % ARR) == 0);
    endfunction

    task automatic step(input bit rst, input bit l_n, input bit r_n, input bit rot_n);
        bit conflict;
        reset = rst;
        key_left_n = l_n;
        key_right_n = r_n;
        key_rot_n = rot_n;
        @(posedge CLOCK_50);
        if (rst) begin
            k = 0;
            for (int c = 0; c < 3; c++) begin
                d_hist[c][0] = 1'b0;
                last_flip[c] = 0;
                rise_edge[c] = -1;
            end
            exp_l = 0; exp_r = 0; exp_rot = 0; exp_held = '0;
        end else begin
            if (k >= HMAX - 1) begin
                $display("FAIL model_history k=%0d exceeds limit %0d", k, HMAX - 1);
                $fatal(1, "history overflow");
            end
            k++;
            p_hist[0][k] = !l_n;
            p_hist[1][k] = !r_n;
            p_hist[2][k] = !rot_n;
            for (int c = 0; c < 3; c++) begin
                if (deb_flips(c)) begin
                    d_hist[c][k] = !d_hist[c][k-1];
                    last_flip[c] = k;
                    if (d_hist[c][k]) rise_edge[c] = k;
                end else begin
                    d_hist[c][k] = d_hist[c][k-1];
                end
            end
            conflict = d_hist[0][k-1] & d_hist[1][k-1];
            exp_held = {d_hist[2][k], d_hist[1][k], d_hist[0][k]};
            exp_l    = rpt_due(0) & !conflict;
            exp_r    = rpt_due(1) & !conflict;
            exp_rot  = d_hist[2][k-1] && (rise_edge[2] == k - 1);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 25; i++) begin
            step(i < 5, 1, 1, 1);
            n_cmp++;
            if ({left_final, right_final, rot_final, btn_held} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got=%b required=000000", i,
                         {left_final, right_final, rot_final, btn_held});
            end
        end
        $display("test_reset done, compared=%0d", n_cmp);
    endtask

    task automatic test_left_hold();
        int pulses[$];
        int first_held = -1;
        int exp_pulses[6] = '{7, 17, 20, 23, 26, 29};
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        for (int i = 1; i <= 45; i++) begin
            step(0, i > 30, 1, 1);
            n_cmp++;
            if ({left_final, right_final, rot_final, btn_held} !== {exp_l, exp_r, exp_rot, exp_held}) begin
                n_bad++;
                $display("FAIL left_hold k=%0d got=%b required=%b", k,
                         {left_final, right_final, rot_final, btn_held}, {exp_l, exp_r, exp_rot, exp_held});
            end
            if (left_final) pulses.push_back(k);
            if (btn_held[0] && first_held < 0) first_held = k;
            if (k > 36) begin
                n_cmp++;
                if (left_final !== 1'b0 || btn_held[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL left_after_release k=%0d got pulse=%b held=%b required 0/0", k,
                             left_final, btn_held[0]);
                end
            end
        end
        n_cmp++;
        if (first_held != 6) begin
            n_bad++;
            $display("FAIL left_held_start got=%0d required=6", first_held);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= pulses.size() || pulses[i] != exp_pulses[i]) begin
                n_bad++;
                $display("FAIL left_pulse_time idx=%0d got=%0d required=%0d", i,
                         (i < pulses.size()) ? pulses[i] : -1, exp_pulses[i]);
            end
        end
        $display("test_left_hold done, pulses=%0d", pulses.size());
    endtask

    task automatic test_bounce();
        int cnt = 0;
        int at = -1;
        step(1, 1, 1, 1);
        for (int i = 1; i <= 40; i++) begin
            step(0, 1, (i <= 12) ? (((i - 1) / 2) % 2 == 1) : (i > 28), 1);
            n_cmp++;
            if ({left_final, right_final, rot_final, btn_held} !== {exp_l, exp_r, exp_rot, exp_held}) begin
                n_bad++;
                $display("FAIL bounce k=%0d got=%b required=%b", k,
                         {left_final, right_final, rot_final, btn_held}, {exp_l, exp_r, exp_rot, exp_held});
            end
            if (right_final && k <= 28) begin
                cnt++;
                at = k;
            end
        end
        n_cmp++;
        if (cnt != 1 || at != 19) begin
            n_bad++;
            $display("FAIL bounce_single_pulse got count=%0d at=%0d required count=1 at=19", cnt, at);
        end
        $display("test_bounce done, right pulses=%0d", cnt);
    endtask

    task automatic test_rot();
        int cnt = 0;
        int at = -1;
        step(1, 1, 1, 1);
        for (int i = 1; i <= 50; i++) begin
            step(0, 1, 1, i > 40);
            n_cmp++;
            if ({left_final, right_final, rot_final, btn_held} !== {exp_l, exp_r, exp_rot, exp_held}) begin
                n_bad++;
                $display("FAIL rot k=%0d got=%b required=%b", k,
                         {left_final, right_final, rot_final, btn_held}, {exp_l, exp_r, exp_rot, exp_held});
            end
            if (rot_final) begin
                cnt++;
                at = k;
            end
        end
        n_cmp++;
        if (cnt != 1 || at != 7) begin
            n_bad++;
            $display("FAIL rot_single_pulse got count=%0d at=%0d required count=1 at=7", cnt, at);
        end
        $display("test_rot done, rot pulses=%0d", cnt);
    endtask

    task automatic test_conflict();
        int lr_cnt = 0;
        int rot_cnt = 0;
        step(1, 1, 1, 1);
        for (int i = 1; i <= 60; i++) begin
            step(0, 0, i > 35, !(i >= 10 && i < 20));
            n_cmp++;
            if ({left_final, right_final, rot_final, btn_held} !== {exp_l, exp_r, exp_rot, exp_held}) begin
                n_bad++;
                $display("FAIL conflict k=%0d got=%b required=%b", k,
                         {left_final, right_final, rot_final, btn_held}, {exp_l, exp_r, exp_rot, exp_held});
            end
            if (k <= 40 && (left_final || right_final)) lr_cnt++;
            if (rot_final) rot_cnt++;
        end
        n_cmp++;
        if (lr_cnt != 0 || rot_cnt != 1) begin
            n_bad++;
            $display("FAIL conflict_counts got lr=%0d rot=%0d required lr=0 rot=1", lr_cnt, rot_cnt);
        end
        $display("test_conflict done, masked overlap ok=%0d", (lr_cnt == 0));
    endtask

    task automatic test_reset_midhold();
        int pulses[$];
        step(1, 1, 1, 1);
        for (int i = 1; i <= 11; i++) step(0, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 1, 1);
            n_cmp++;
            if ({left_final, right_final, rot_final, btn_held} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_midhold_clear got=%b required=000000",
                         {left_final, right_final, rot_final, btn_held});
            end
        end
        for (int i = 1; i <= 25; i++) begin
            step(0, 0, 1, 1);
            n_cmp++;
            if ({left_final, right_final, rot_final, btn_held} !== {exp_l, exp_r, exp_rot, exp_held}) begin
                n_bad++;
                $display("FAIL reset_midhold k=%0d got=%b required=%b", k,
                         {left_final, right_final, rot_final, btn_held}, {exp_l, exp_r, exp_rot, exp_held});
            end
            if (left_final) pulses.push_back(k);
        end
        n_cmp++;
        if (pulses.size() < 3 || pulses[0] != 7 || pulses[1] != 17 || pulses[2] != 20) begin
            n_bad++;
            $display("FAIL reset_midhold_pulses got n=%0d first=%0d required 7,17,20", pulses.size(),
                     (pulses.size() > 0) ? pulses[0] : -1);
        end
        $display("test_reset_midhold done, pulses=%0d", pulses.size());
    endtask

    task automatic test_random();
        bit lvl[3];
        int hold[3];
        int pulses = 0;
        for (int round = 0; round < 6; round++) begin
            step(1, 1, 1, 1);
            for (int c = 0; c < 3; c++) begin
                lvl[c] = 1'b1;
                hold[c] = 0;
            end
            for (int i = 0; i < 200; i++) begin
                for (int c = 0; c < 3; c++) begin
                    if (hold[c] == 0) begin
                        lvl[c] = !lvl[c];
                        hold[c] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : $urandom_range(5, 40);
                    end
                    hold[c]--;
                end
                step(0, lvl[0], lvl[1], lvl[2]);
                n_cmp++;
                if ({left_final, right_final, rot_final, btn_held} !== {exp_l, exp_r, exp_rot, exp_held}) begin
                    n_bad++;
                    $display("FAIL random r=%0d k=%0d got=%b required=%b", round, k,
                             {left_final, right_final, rot_final, btn_held}, {exp_l, exp_r, exp_rot, exp_held});
                end
                pulses += int'(left_final) + int'(right_final) + int'(rot_final);
            end
        end
        $display("test_random done, pulses seen=%0d", pulses);
    endtask

    initial begin
        test_reset();
        test_left_hold();
        test_bounce();
        test_rot();
        test_conflict();
        test_reset_midhold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
